// File: rtl/call_stack.sv
// Hardware return stack: saves {return PC, flags} on call and presents the top entry
// combinationally, so the control unit can restore both on the edge that pops it.
module call_stack #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned FLAGS_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_push_en,
    input  logic                           in_pop_en,
    input  logic [PC_WIDTH-1:0]            in_pc,
    input  logic [FLAGS_WIDTH-1:0]         in_flags,
    input  logic                           in_clear_err,
    output logic [PC_WIDTH-1:0]            out_pc,
    output logic [FLAGS_WIDTH-1:0]         out_flags,
    output logic                           out_empty,
    output logic                           out_full,
    output logic [$clog2(DEPTH+1)-1:0]     out_depth,
    output logic                           out_overflow,
    output logic                           out_underflow
);

    localparam int unsigned SP_W    = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = PC_WIDTH + FLAGS_WIDTH;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;
    logic [ENTRY_W-1:0] top_entry;
    logic               empty, full;

    // Status and top-of-stack read path, all derived from sp
    always_comb begin
        empty     = (sp_q == SP_W'(0));
        full      = (sp_q == SP_W'(DEPTH));
        top_idx   = empty ? IDX_W'(0) : IDX_W'(sp_q - SP_W'(1));
        top_entry = empty ? ENTRY_W'(0) : mem_q[top_idx];
    end

    assign out_pc        = top_entry[ENTRY_W-1:FLAGS_WIDTH];
    assign out_flags     = top_entry[FLAGS_WIDTH-1:0];
    assign out_empty     = empty;
    assign out_full      = full;
    assign out_depth     = sp_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;

    // Next stack pointer, write port and sticky errors; a new error overrides a clear
    always_comb begin
        sp_d   = sp_q;
        wr_en  = 1'b0;
        wr_idx = IDX_W'(sp_q);
        ovf_d  = in_clear_err ? 1'b0 : ovf_q;
        unf_d  = in_clear_err ? 1'b0 : unf_q;
        case ({in_push_en, in_pop_en})
            2'b10: begin
                if (!full) begin
                    wr_en  = 1'b1;
                    wr_idx = IDX_W'(sp_q);
                    sp_d   = sp_q + SP_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    sp_d = sp_q - SP_W'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (!empty) begin
                    wr_idx = top_idx;
                end else begin
                    wr_idx = IDX_W'(0);
                    sp_d   = SP_W'(1);
                    unf_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= SP_W'(0);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage is deliberately not reset; sp alone defines validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= {in_pc, in_flags};
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Directed table-driven bench for call_stack plus hand-written multi-cycle corner sequences.
module tb_call_stack;

    logic       clk;
    logic       rst_n;
    logic       push, pop, clr;
    logic [7:0] pc;
    logic [3:0] fl;
    logic [7:0] o_pc;
    logic [3:0] o_fl;
    logic       o_empty, o_full, o_ovf, o_unf;
    logic [3:0] o_depth;

    int checks = 0;
    int errors = 0;

    call_stack #(.DEPTH(8), .PC_WIDTH(8), .FLAGS_WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_push_en   (push),
        .in_pop_en    (pop),
        .in_pc        (pc),
        .in_flags     (fl),
        .in_clear_err (clr),
        .out_pc       (o_pc),
        .out_flags    (o_fl),
        .out_empty    (o_empty),
        .out_full     (o_full),
        .out_depth    (o_depth),
        .out_overflow (o_ovf),
        .out_underflow(o_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push, pop, clr;
        logic [7:0] pc;
        logic [3:0] fl;
        logic [7:0] e_pc;
        logic [3:0] e_fl;
        logic       e_empty, e_full;
        logic [3:0] e_depth;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ps, input logic pp, input logic cl,
                       input logic [7:0] ipc, input logic [3:0] ifl,
                       input logic [7:0] epc, input logic [3:0] efl,
                       input logic ee, input logic ef, input logic [3:0] ed,
                       input logic eo, input logic eu);
        vec_t v;
        v.push = ps; v.pop = pp; v.clr = cl; v.pc = ipc; v.fl = ifl;
        v.e_pc = epc; v.e_fl = efl; v.e_empty = ee; v.e_full = ef;
        v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
        vecs.push_back(v);
    endtask

    // Packed view {pc, flags, empty, full, depth, ovf, unf}
    function automatic logic [19:0] pack(input logic [7:0] p, input logic [3:0] f,
                                         input logic e, input logic fu, input logic [3:0] d,
                                         input logic ov, input logic un);
        return {p, f, e, fu, d, ov, un};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h ({pc,fl,empty,full,depth,ovf,unf})",
                     name, act, exp);
        end
    endtask

    function automatic logic [19:0] dut_state();
        return pack(o_pc, o_fl, o_empty, o_full, o_depth, o_ovf, o_unf);
    endfunction

    task automatic idle();
        push = 1'b0; pop = 1'b0; clr = 1'b0; pc = 8'h00; fl = 4'h0;
    endtask

    task automatic step(input logic ps, input logic pp, input logic cl,
                        input logic [7:0] ipc, input logic [3:0] ifl);
        push = ps; pop = pp; clr = cl; pc = ipc; fl = ifl;
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Build the vector table
        add(1,0,0, 8'h12,4'h1, 8'h12,4'h1, 0,0,4'd1, 0,0);
        add(1,0,0, 8'h34,4'h2, 8'h34,4'h2, 0,0,4'd2, 0,0);
        add(0,1,0, 8'h00,4'h0, 8'h12,4'h1, 0,0,4'd1, 0,0);
        add(0,1,0, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,0);
        for (int i = 0; i < 8; i++)
            add(1,0,0, 8'(i),4'(i), 8'(i),4'(i), 0,(i == 7),4'(i + 1), 0,0);
        add(1,0,0, 8'hFF,4'hF, 8'h07,4'h7, 0,1,4'd8, 1,0);
        for (int k = 0; k < 8; k++) begin
            if (k < 7) add(0,1,0, 8'h00,4'h0, 8'(6 - k),4'(6 - k), 0,0,4'(7 - k), 1,0);
            else       add(0,1,0, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 1,0);
        end
        add(0,0,1, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,0);
        add(0,1,0, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,1);
        add(0,0,0, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,1);
        add(0,0,1, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,0);
        add(1,1,0, 8'h56,4'h5, 8'h56,4'h5, 0,0,4'd1, 0,1);
        add(0,1,1, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,0);
        add(0,1,1, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,1);
        add(0,0,1, 8'h00,4'h0, 8'h00,4'h0, 1,0,4'd0, 0,0);
        add(1,0,0, 8'h01,4'h1, 8'h01,4'h1, 0,0,4'd1, 0,0);
        add(1,0,0, 8'h02,4'h2, 8'h02,4'h2, 0,0,4'd2, 0,0);
        add(1,0,0, 8'h03,4'h3, 8'h03,4'h3, 0,0,4'd3, 0,0);
        add(1,1,0, 8'hAA,4'hA, 8'hAA,4'hA, 0,0,4'd3, 0,0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", dut_state(), pack(8'h00,4'h0,1,0,4'd0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", dut_state(), pack(8'h00,4'h0,1,0,4'd0,0,0));

        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].pc, vecs[i].fl);
            check($sformatf("vec%0d", i), dut_state(),
                  pack(vecs[i].e_pc, vecs[i].e_fl, vecs[i].e_empty, vecs[i].e_full,
                       vecs[i].e_depth, vecs[i].e_ovf, vecs[i].e_unf));
        end

        // Replace-top: old top visible during the strobe cycle, new one after the edge
        push = 1'b1; pop = 1'b1; pc = 8'hBB; fl = 4'hB;
        #1;
        check("replace_pre", dut_state(), pack(8'hAA,4'hA,0,0,4'd3,0,0));
        @(posedge clk);
        #1;
        idle();
        check("replace_post", dut_state(), pack(8'hBB,4'hB,0,0,4'd3,0,0));

        // Pop: popped entry visible during its cycle
        pop = 1'b1;
        #1;
        check("pop_pre", dut_state(), pack(8'hBB,4'hB,0,0,4'd3,0,0));
        @(posedge clk);
        #1;
        idle();
        check("pop_post", dut_state(), pack(8'h02,4'h2,0,0,4'd2,0,0));

        // Depth 4, then asynchronous reset mid-cycle
        step(1,0,0, 8'h44,4'h4);
        step(1,0,0, 8'h55,4'h5);
        check("depth4", dut_state(), pack(8'h55,4'h5,0,0,4'd4,0,0));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_state(), pack(8'h00,4'h0,1,0,4'd0,0,0));
        @(negedge clk);
        rst_n = 1'b1;
        pop = 1'b1;
        @(posedge clk);
        #1;
        idle();
        check("pop_after_reset", dut_state(), pack(8'h00,4'h0,1,0,4'd0,0,1));
        step(0,0,1, 8'h00,4'h0);

        // Replace top while full: no overflow
        for (int i = 0; i < 8; i++) step(1,0,0, 8'(8'h80 + i), 4'(i));
        check("full", dut_state(), pack(8'h87,4'h7,0,1,4'd8,0,0));
        step(1,1,0, 8'hCC,4'hC);
        check("full_replace", dut_state(), pack(8'hCC,4'hC,0,1,4'd8,0,0));
        step(0,1,0, 8'h00,4'h0);
        check("full_pop", dut_state(), pack(8'h86,4'h6,0,0,4'd7,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
